control_colocacion: RTL and testbench
=====================================

# control_colocacion

Ship-placement sequencer for the battleship board. It takes the player's cursor, rotate and confirm inputs and checks each candidate ship cell by cell against board bounds and an internal occupancy map. Each accepted ship is written into its own `registroB` instance through a one-hot enable with a shared `casilla`/`tipo` bus. It sits between the debounced button logic and the bank of `NUM_BARCOS` ship registers.

## Interface
- `FILAS`, 5: board rows.
- `COLS`, 5: board columns. Cell index `casilla = fila*COLS + col`, range 0..24.
- `NUM_BARCOS`, 5: ships per player. Ship k (0-based) has length `L = k+1` and `tipo = k+1`.

- `clk`  in  1  single clock, all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `iniciar`  in  1  start/restart pulse; honoured only in REPOSO or LISTO.
- `mover_der`  in  1  cursor column +1 with wrap.
- `mover_abj`  in  1  cursor row +1 with wrap.
- `rotar`  in  1  toggle orientation.
- `confirmar`  in  1  request placement of the current ship.
- `cursor`  out  5  current anchor cell.
- `orientacion`  out  1  0 = horizontal (increasing col), 1 = vertical (increasing row).
- `barco_idx`  out  3  index k of the ship being placed.
- `en_barco`  out  NUM_BARCOS  one-hot write enable to ship register k.
- `casilla_out`  out  5  anchor cell presented to ship registers.
- `tipo_out`  out  3  ship type presented to ship registers.
- `ocupado`  out  FILAS*COLS  occupancy map; bit i = cell i.
- `error`  out  1  one-cycle pulse on rejected placement.
- `listo`  out  1  level; all ships placed.

## Operation
- States: REPOSO, ESPERA, VALIDAR, ESCRIBIR, RECHAZO, LISTO.
- REPOSO: `iniciar` clears `ocupado`, sets k=0, cursor=0 and orientacion=0, then goes to ESPERA.
- ESPERA accepts one input per cycle, in priority order `confirmar` > `rotar` > `mover_der` > `mover_abj`:
  - `confirmar` loads j=0 and goes to VALIDAR.
  - `mover_der`: col = (col+1) mod COLS; row unchanged. Example: 4→0 on the same row.
  - `mover_abj`: row = (row+1) mod FILAS; col unchanged.
  - All movement inputs are ignored outside ESPERA.
- VALIDAR checks one cell j per cycle, for j = 0..L-1.
  - Cell address: `cursor + j` when horizontal, `cursor + j*COLS` when vertical.
  - Out of bounds: horizontal `col+j >= COLS`, or vertical `fila+j >= FILAS`.
  - An out-of-bounds cell or a set `ocupado` bit goes to RECHAZO immediately.
  - When j = L-1 passes, go to ESCRIBIR with j=0.
- ESCRIBIR sets the `ocupado` bit for cell j, one cell per cycle.
  - On the last cycle (j = L-1), `en_barco[k]` is asserted, `casilla_out` = cursor and `tipo_out` = k+1.
  - Next state: LISTO with `listo`=1 if k = NUM_BARCOS-1; otherwise k+1 and ESPERA.
  - Cursor and orientation are preserved for the next ship.
- RECHAZO asserts `error` for one cycle, then returns to ESPERA. k, cursor, orientation and `ocupado` are unchanged.
- LISTO holds the board. `iniciar` restarts exactly as from REPOSO and clears `listo`.
- `iniciar` in any other state is ignored.
- Address arithmetic is 5-bit unsigned and is evaluated only after the bounds check, so it never wraps into a wrong cell.

## Timing
- Reset values: state REPOSO, `cursor`=0, `orientacion`=0, `barco_idx`=0, `en_barco`=0, `casilla_out`=0, `tipo_out`=0, `ocupado`=0, `error`=0, `listo`=0.
- Reset is synchronous and wins over every input. Reset mid-VALIDAR or mid-ESCRIBIR abandons the ship; no `en_barco` pulse is produced.
- `iniciar` sampled at edge t: ESPERA from cycle t+1.
- `confirmar` sampled at edge t with a valid ship:
  - VALIDAR occupies cycles t+1..t+L; ESCRIBIR occupies t+L+1..t+2L.
  - `en_barco[k]` is high only in cycle t+2L. `registroB` captures at the end of that cycle.
  - Next state is ESPERA or LISTO at t+2L+1.
- Rejection at VALIDAR cycle j: `error` is high in the following cycle, and ESPERA resumes one cycle after that.
- `en_barco` is never multi-hot and never asserted outside ESCRIBIR.
- All outputs are registered.

## Test plan
- Reset, then hold idle 5 cycles -> all outputs 0; state REPOSO; `listo`=0.
- `iniciar`, then `confirmar` at cursor 0 -> `en_barco`=00001 for exactly one cycle, 2 cycles after the confirm edge; `casilla_out`=0; `tipo_out`=1; `ocupado` bit0=1.
- Ship 2 (L=3), horizontal, cursor moved to col 3 row 0 (cell 3), `confirmar` -> `error` pulse; `ocupado` unchanged. After `rotar` and re-confirm -> accepted; `ocupado` bits 3, 8 and 13 set.
- Overlap: ship 0 at cell 0, ship 1 vertical at cell 0 -> `error` on the first VALIDAR cell. Move to cell 1 and confirm -> bits 1 and 6 set, `tipo_out`=2.
- Wrap: 5× `mover_der` returns cursor to the same cell. `mover_abj` from row 4 wraps to row 0. `mover_der` and `mover_abj` asserted together move only the column.
- Full sequence: place all 5 ships -> `listo`=1 with 15 `ocupado` bits set. Then assert `rst` mid-ESCRIBIR of a fresh run -> all outputs 0 the next cycle and no `en_barco` pulse.

Source files
------------

// File: rtl/control_colocacion.sv
// Ship-placement sequencer: moves a cursor over the board, validates each candidate
// ship cell by cell against bounds and the occupancy map, then writes it out.
module control_colocacion #(
  parameter int FILAS      = 5,
  parameter int COLS       = 5,
  parameter int NUM_BARCOS = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     iniciar,
  input  logic                     mover_der,
  input  logic                     mover_abj,
  input  logic                     rotar,
  input  logic                     confirmar,
  output logic [4:0]               cursor,
  output logic                     orientacion,
  output logic [2:0]               barco_idx,
  output logic [NUM_BARCOS-1:0]    en_barco,
  output logic [4:0]               casilla_out,
  output logic [2:0]               tipo_out,
  output logic [FILAS*COLS-1:0]    ocupado,
  output logic                     error,
  output logic                     listo
);

  localparam int                  NCELDAS = FILAS * COLS;
  localparam logic [4:0]          COLS5   = 5'(COLS);
  localparam logic [3:0]          COLS4   = 4'(COLS);
  localparam logic [3:0]          FILAS4  = 4'(FILAS);
  localparam logic [2:0]          COL_MAX = 3'(COLS - 1);
  localparam logic [2:0]          FIL_MAX = 3'(FILAS - 1);
  localparam logic [2:0]          K_MAX   = 3'(NUM_BARCOS - 1);
  localparam logic [NUM_BARCOS-1:0] UNO   = {{(NUM_BARCOS-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    REPOSO, ESPERA, VALIDAR, ESCRIBIR, RECHAZO, LISTO
  } estado_t;

  estado_t               estado_q, estado_d;
  logic [2:0]            fila_q, fila_d, col_q, col_d;
  logic [4:0]            cursor_q, cursor_d;
  logic                  orient_q, orient_d;
  logic [2:0]            k_q, k_d, j_q, j_d;
  logic [NCELDAS-1:0]    ocupado_q, ocupado_d;
  logic [NUM_BARCOS-1:0] en_barco_q, en_barco_d;
  logic [4:0]            casilla_q, casilla_d;
  logic [2:0]            tipo_q, tipo_d;
  logic                  error_q, error_d;
  logic                  listo_q, listo_d;

  logic                  fuera;
  logic [4:0]            celda;

  // The cell address may overflow when out of bounds; it is only consumed after fuera is clear.
  assign fuera = orient_q ? ({1'b0, fila_q} + {1'b0, j_q} >= FILAS4)
                          : ({1'b0, col_q}  + {1'b0, j_q} >= COLS4);
  assign celda = orient_q ? cursor_q + ({2'b0, j_q} * COLS5)
                          : cursor_q + {2'b0, j_q};

  always_comb begin
    // NOTE: every _d gets a default first so no path through the case infers a latch.
    estado_d   = estado_q;
    fila_d     = fila_q;
    col_d      = col_q;
    orient_d   = orient_q;
    k_d        = k_q;
    j_d        = j_q;
    ocupado_d  = ocupado_q;
    en_barco_d = '0;
    casilla_d  = casilla_q;
    tipo_d     = tipo_q;
    error_d    = 1'b0;
    listo_d    = listo_q;

    case (estado_q)
      REPOSO, LISTO: begin
        if (iniciar) begin
          estado_d  = ESPERA;
          fila_d    = '0;
          col_d     = '0;
          orient_d  = 1'b0;
          k_d       = '0;
          j_d       = '0;
          ocupado_d = '0;
          listo_d   = 1'b0;
        end
      end
      ESPERA: begin
        if (confirmar) begin
          j_d      = '0;
          estado_d = VALIDAR;
        end else if (rotar) begin
          orient_d = ~orient_q;
        end else if (mover_der) begin
          col_d = (col_q == COL_MAX) ? 3'd0 : col_q + 3'd1;
        end else if (mover_abj) begin
          fila_d = (fila_q == FIL_MAX) ? 3'd0 : fila_q + 3'd1;
        end
      end
      VALIDAR: begin
        if (fuera || ocupado_q[celda]) begin
          estado_d = RECHAZO;
          error_d  = 1'b1;
        end else if (j_q == k_q) begin
          estado_d = ESCRIBIR;
          j_d      = '0;
          // A length-1 ship writes in a single cycle, so its enable is raised right away.
          if (k_q == 3'd0) begin
            en_barco_d = UNO << k_q;
            casilla_d  = cursor_q;
            tipo_d     = k_q + 3'd1;
          end
        end else begin
          j_d = j_q + 3'd1;
        end
      end
      ESCRIBIR: begin
        ocupado_d[celda] = 1'b1;
        if (j_q == k_q) begin
          if (k_q == K_MAX) begin
            estado_d = LISTO;
            listo_d  = 1'b1;
          end else begin
            estado_d = ESPERA;
            k_d      = k_q + 3'd1;
          end
        end else begin
          j_d = j_q + 3'd1;
          if (j_q + 3'd1 == k_q) begin
            en_barco_d = UNO << k_q;
            casilla_d  = cursor_q;
            tipo_d     = k_q + 3'd1;
          end
        end
      end
      RECHAZO: estado_d = ESPERA;
      default: estado_d = REPOSO;
    endcase

    cursor_d = ({2'b0, fila_d} * COLS5) + {2'b0, col_d};
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      estado_q   <= REPOSO;
      fila_q     <= '0;
      col_q      <= '0;
      cursor_q   <= '0;
      orient_q   <= 1'b0;
      k_q        <= '0;
      j_q        <= '0;
      ocupado_q  <= '0;
      en_barco_q <= '0;
      casilla_q  <= '0;
      tipo_q     <= '0;
      error_q    <= 1'b0;
      listo_q    <= 1'b0;
    end else begin
      estado_q   <= estado_d;
      fila_q     <= fila_d;
      col_q      <= col_d;
      cursor_q   <= cursor_d;
      orient_q   <= orient_d;
      k_q        <= k_d;
      j_q        <= j_d;
      ocupado_q  <= ocupado_d;
      en_barco_q <= en_barco_d;
      casilla_q  <= casilla_d;
      tipo_q     <= tipo_d;
      error_q    <= error_d;
      listo_q    <= listo_d;
    end
  end

  assign cursor      = cursor_q;
  assign orientacion = orient_q;
  assign barco_idx   = k_q;
  assign en_barco    = en_barco_q;
  assign casilla_out = casilla_q;
  assign tipo_out    = tipo_q;
  assign ocupado     = ocupado_q;
  assign error       = error_q;
  assign listo       = listo_q;

endmodule

// File: tb/tb_control_colocacion.sv
// Directed bench for control_colocacion: placement, rejection, wrap, full board and reset abort.
module tb_control_colocacion;

  logic        clk = 1'b0;
  logic        rst, iniciar, mover_der, mover_abj, rotar, confirmar;
  logic [4:0]  cursor, casilla_out;
  logic        orientacion, error, listo;
  logic [2:0]  barco_idx, tipo_out;
  logic [4:0]  en_barco;
  logic [24:0] ocupado;

  int tests = 0;
  int fails = 0;

  control_colocacion dut (
    .clk(clk), .rst(rst), .iniciar(iniciar), .mover_der(mover_der),
    .mover_abj(mover_abj), .rotar(rotar), .confirmar(confirmar),
    .cursor(cursor), .orientacion(orientacion), .barco_idx(barco_idx),
    .en_barco(en_barco), .casilla_out(casilla_out), .tipo_out(tipo_out),
    .ocupado(ocupado), .error(error), .listo(listo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Holds the given inputs for one sampling edge; returns in the cycle after that edge.
  task automatic drive(input logic ini, input logic cf, input logic rot,
                       input logic der, input logic abj);
    iniciar = ini; confirmar = cf; rotar = rot; mover_der = der; mover_abj = abj;
    tick();
    iniciar = 0; confirmar = 0; rotar = 0; mover_der = 0; mover_abj = 0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".cursor"},   32'(cursor),      0);
    check({tag, ".orient"},   32'(orientacion), 0);
    check({tag, ".barco"},    32'(barco_idx),   0);
    check({tag, ".en"},       32'(en_barco),    0);
    check({tag, ".casilla"},  32'(casilla_out), 0);
    check({tag, ".tipo"},     32'(tipo_out),    0);
    check({tag, ".ocupado"},  32'(ocupado),     0);
    check({tag, ".error"},    32'(error),       0);
    check({tag, ".listo"},    32'(listo),       0);
  endtask

  always @(negedge clk) begin
    if (!rst) check("en_onehot0", 32'($onehot0(en_barco)), 1);
  end

  initial begin
    rst = 1; iniciar = 0; mover_der = 0; mover_abj = 0; rotar = 0; confirmar = 0;
    ticks(2);
    rst = 0;
    ticks(5);
    check_zero("reset_idle");

    drive(1, 0, 0, 0, 0);
    check("start.cursor", 32'(cursor), 0);
    check("start.barco",  32'(barco_idx), 0);

    // Ship 0 (L=1) at cell 0: enable two cycles after the confirm edge.
    drive(0, 1, 0, 0, 0);
    check("s0.en_early", 32'(en_barco), 0);
    tick();
    check("s0.en",      32'(en_barco), 'h01);
    check("s0.casilla", 32'(casilla_out), 0);
    check("s0.tipo",    32'(tipo_out), 1);
    tick();
    check("s0.en_after", 32'(en_barco), 0);
    check("s0.ocupado",  32'(ocupado), 'h1);
    check("s0.barco",    32'(barco_idx), 1);

    // Ship 1 vertical at cell 0 overlaps ship 0 on its first cell.
    drive(0, 0, 1, 0, 0);
    check("rot.orient", 32'(orientacion), 1);
    drive(0, 1, 0, 0, 0);
    check("ovl.err_early", 32'(error), 0);
    tick();
    check("ovl.error", 32'(error), 1);
    tick();
    check("ovl.err_after", 32'(error), 0);
    check("ovl.ocupado",   32'(ocupado), 'h1);
    check("ovl.barco",     32'(barco_idx), 1);

    // Ship 1 vertical at cell 1: cells 1, 6.
    drive(0, 0, 0, 1, 0);
    check("s1.cursor", 32'(cursor), 1);
    drive(0, 1, 0, 0, 0);
    ticks(2);
    check("s1.en_early", 32'(en_barco), 0);
    tick();
    check("s1.en",      32'(en_barco), 'h02);
    check("s1.casilla", 32'(casilla_out), 1);
    check("s1.tipo",    32'(tipo_out), 2);
    tick();
    check("s1.en_after", 32'(en_barco), 0);
    check("s1.ocupado",  32'(ocupado), 'h43);
    check("s1.barco",    32'(barco_idx), 2);

    // Ship 2 horizontal at cell 3 runs past column 4 on its third cell.
    drive(0, 0, 1, 0, 0);
    drive(0, 0, 0, 1, 0);
    drive(0, 0, 0, 1, 0);
    check("s2h.cursor", 32'(cursor), 3);
    check("s2h.orient", 32'(orientacion), 0);
    drive(0, 1, 0, 0, 0);
    ticks(2);
    check("oob.err_early", 32'(error), 0);
    tick();
    check("oob.error", 32'(error), 1);
    tick();
    check("oob.err_after", 32'(error), 0);
    check("oob.ocupado",   32'(ocupado), 'h43);

    // Ship 2 vertical at cell 3: cells 3, 8, 13.
    drive(0, 0, 1, 0, 0);
    drive(0, 1, 0, 0, 0);
    ticks(4);
    check("s2.en_early", 32'(en_barco), 0);
    tick();
    check("s2.en",      32'(en_barco), 'h04);
    check("s2.casilla", 32'(casilla_out), 3);
    check("s2.tipo",    32'(tipo_out), 3);
    tick();
    check("s2.ocupado", 32'(ocupado), 'h214B);
    check("s2.barco",   32'(barco_idx), 3);

    // Cursor wrap in both axes; simultaneous moves honour only the column.
    for (int i = 0; i < 5; i++) drive(0, 0, 0, 1, 0);
    check("wrap.col", 32'(cursor), 3);
    for (int i = 0; i < 4; i++) drive(0, 0, 0, 0, 1);
    check("wrap.row4", 32'(cursor), 23);
    drive(0, 0, 0, 0, 1);
    check("wrap.row0", 32'(cursor), 3);
    drive(0, 0, 0, 1, 1);
    check("both.cursor", 32'(cursor), 4);

    // Ship 3 vertical at cell 4: cells 4, 9, 14, 19.
    drive(0, 1, 0, 0, 0);
    ticks(6);
    check("s3.en_early", 32'(en_barco), 0);
    tick();
    check("s3.en",      32'(en_barco), 'h08);
    check("s3.casilla", 32'(casilla_out), 4);
    check("s3.tipo",    32'(tipo_out), 4);
    tick();
    check("s3.ocupado", 32'(ocupado), 'h8635B);

    // Ship 4 vertical at cell 2: cells 2, 7, 12, 17, 22; board complete.
    drive(0, 0, 0, 1, 0);
    check("s4.wrap", 32'(cursor), 0);
    drive(0, 0, 0, 1, 0);
    drive(0, 0, 0, 1, 0);
    check("s4.cursor", 32'(cursor), 2);
    drive(0, 1, 0, 0, 0);
    ticks(8);
    check("s4.en_early", 32'(en_barco), 0);
    check("s4.listo_early", 32'(listo), 0);
    tick();
    check("s4.en",      32'(en_barco), 'h10);
    check("s4.casilla", 32'(casilla_out), 2);
    check("s4.tipo",    32'(tipo_out), 5);
    tick();
    check("done.listo",   32'(listo), 1);
    check("done.ocupado", 32'(ocupado), 'h4A73DF);
    check("done.count",   32'($countones(ocupado)), 15);

    // LISTO ignores movement and confirm.
    drive(0, 0, 0, 1, 0);
    check("listo.cursor", 32'(cursor), 2);
    drive(0, 1, 0, 0, 0);
    ticks(3);
    check("listo.en",    32'(en_barco), 0);
    check("listo.hold",  32'(listo), 1);

    // Restart clears the board.
    drive(1, 0, 0, 0, 0);
    check("rst2.listo",   32'(listo), 0);
    check("rst2.ocupado", 32'(ocupado), 0);
    check("rst2.cursor",  32'(cursor), 0);
    check("rst2.orient",  32'(orientacion), 0);
    check("rst2.barco",   32'(barco_idx), 0);

    // Fresh run: ship 0, then reset in the first ESCRIBIR cycle of ship 1.
    drive(0, 1, 0, 0, 0);
    ticks(2);
    check("f0.ocupado", 32'(ocupado), 'h1);
    drive(0, 0, 0, 1, 0);
    check("f1.cursor", 32'(cursor), 1);
    drive(0, 1, 0, 0, 0);
    check("f1.en_v0", 32'(en_barco), 0);
    tick();
    check("f1.en_v1", 32'(en_barco), 0);
    tick();
    check("f1.en_w0", 32'(en_barco), 0);
    rst = 1;
    tick();
    rst = 0;
    check_zero("abort");
    ticks(3);
    check_zero("abort_idle");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
